// File: rtl/fir_sym_stream.sv
// Symmetric odd-tap FIR: pre-adder plus one multiplier, time-multiplexed
// over HALF MAC cycles per sample, with valid/ready streams and loadable taps.
module fir_sym_stream #(
    parameter int TAPS = 11,
    parameter int DW = 17,
    parameter int CW = 17,
    parameter int GW = 4,
    localparam int OW = DW + CW + GW,
    localparam int HALF = (TAPS + 1) / 2,
    localparam int CAW = $clog2(HALF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 coef_we,
    input  logic [CAW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data
);

    localparam int IW = $clog2(HALF + 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DW-1:0] r_x [TAPS];
    logic signed [CW-1:0] r_c [HALF];
    logic signed [OW-1:0] r_acc;
    logic signed [OW-1:0] r_out;
    logic [IW-1:0]        r_idx;
    logic                 r_valid;

    logic                    w_accept;
    logic                    w_cwe;
    logic                    w_done;
    logic signed [CW-1:0]    w_coef;
    logic signed [DW-1:0]    w_xa;
    logic signed [DW-1:0]    w_xb;
    logic signed [DW:0]      w_pre;
    logic signed [DW+CW:0]   w_prod;
    logic signed [OW-1:0]    w_ext;

    assign w_accept = in_valid & in_ready & ~clear;
    assign w_cwe = coef_we & coef_ready & ~clear
                 & ({1'b0, coef_addr} < (CAW + 1)'(HALF));
    assign w_done = (r_idx == IW'(HALF));

    assign out_valid = r_valid;
    assign out_data = r_out;

    always_comb begin
        w_next = r_state;
        in_ready = 1'b0;
        coef_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                coef_ready = 1'b1;
                if (in_valid) w_next = S_MAC;
            end
            S_MAC: if (w_done) w_next = S_OUT;
            S_OUT: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // The centre tap has no mirror partner, so its second pre-add operand is zero.
    always_comb begin
        w_coef = '0;
        w_xa = '0;
        w_xb = '0;
        for (int k = 0; k < HALF; k++) begin
            if (r_idx == IW'(k)) begin
                w_coef = r_c[k];
                w_xa = r_x[k];
                w_xb = (k == HALF - 1) ? '0 : r_x[TAPS-1-k];
            end
        end
    end

    assign w_pre = {w_xa[DW-1], w_xa} + {w_xb[DW-1], w_xb};
    assign w_prod = w_pre * w_coef;
    assign w_ext = {{(OW-DW-CW-1){w_prod[DW+CW]}}, w_prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
            for (int k = 0; k < HALF; k++) r_c[k] <= '0;
            r_acc <= '0;
            r_out <= '0;
            r_idx <= '0;
            r_valid <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_cwe) r_c[coef_addr] <= coef_data;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int k = TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
                        r_x[0] <= in_data;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_MAC: begin
                    if (w_done) begin
                        r_out <= r_acc;
                        r_valid <= 1'b1;
                    end else begin
                        r_acc <= r_acc + w_ext;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_OUT: if (out_ready) r_valid <= 1'b0;
                default: r_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sym_stream.sv
// Directed bench for fir_sym_stream: vector table for the streaming path,
// hand sequences for backpressure, clear, coefficient timing and reset.
module tb_fir_sym_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic coef_we = 1'b0;
    logic [2:0] coef_addr = '0;
    logic signed [16:0] coef_data = '0;
    logic coef_ready;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [16:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [37:0] out_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic signed [16:0] din;
        logic signed [37:0] exp;
        bit chk;
    } vec_t;

    vec_t tbl [35];
    logic signed [37:0] h [11];
    logic signed [16:0] cset [6];

    always #5 clk = ~clk;

    fir_sym_stream dut (
        .clk(clk), .rst(rst), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_ready(coef_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = 3'(a);
        coef_data = 17'(d);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({nm, " valid"}, out_valid, 1);
    endtask

    task automatic send(input logic signed [16:0] d,
                        input logic signed [37:0] e,
                        input bit chk, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({nm, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        wait_valid(nm, n);
        check({nm, " latency"}, n, 7);
        if (chk) check({nm, " data"}, out_data, e);
        if (out_ready) tick();
    endtask

    initial begin
        int n;
        cset = '{124, -726, -2697, 2302, 18925, 29552};
        h = '{124, -726, -2697, 2302, 18925, 29552,
              18925, 2302, -2697, -726, 124};
        for (int i = 0; i < 13; i++)
            tbl[i] = '{(i == 0) ? 17'sd1 : 17'sd0,
                       (i < 11) ? h[i] : 38'sd0, 1'b1};
        for (int i = 13; i < 24; i++)
            tbl[i] = '{17'sd65535, 38'sd4286513280, i == 23};
        for (int i = 24; i < 35; i++)
            tbl[i] = '{-17'sd65536, -38'sd4286578688, i == 34};

        #2;
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst in_ready", in_ready, 1);
        check("rst coef_ready", coef_ready, 1);
        #20 rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) wcoef(i, cset[i]);
        wcoef(7, 999);
        wcoef(6, -999);

        for (int i = 0; i < 35; i++)
            send(tbl[i].din, tbl[i].exp, tbl[i].chk, $sformatf("vec%0d", i));

        pulse_clear();
        out_ready = 1'b0;
        send(1, 124, 1, "bp first");
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = 17'sd5;
            tick();
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 124);
            check("bp in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release in_ready", in_ready, 1);
        check("bp release valid", out_valid, 0);
        send(0, -726, 1, "bp next");

        pulse_clear();
        in_valid = 1'b1;
        in_data = 17'sd1;
        tick();
        in_valid = 1'b0;
        coef_we = 1'b1;
        coef_addr = 3'd5;
        coef_data = 17'sd1;
        check("mac coef_ready", coef_ready, 0);
        tick();
        coef_we = 1'b0;
        wait_valid("mac we", n);
        check("mac we first", out_data, 124);
        tick();
        for (int i = 1; i < 6; i++)
            send(0, h[i], 1, $sformatf("mac we tap%0d", i));

        pulse_clear();
        check("idle coef_ready", coef_ready, 1);
        wcoef(5, 1);
        in_valid = 1'b1;
        in_data = 17'sd1;
        coef_we = 1'b1;
        coef_addr = 3'd0;
        coef_data = 17'sd500;
        tick();
        in_valid = 1'b0;
        coef_we = 1'b0;
        wait_valid("same cyc", n);
        check("same cyc coef", out_data, 500);
        tick();
        for (int i = 1; i < 5; i++)
            send(0, h[i], 1, $sformatf("idle we tap%0d", i));
        send(0, 1, 1, "idle we centre");
        wcoef(0, 124);
        wcoef(5, 29552);

        send(3, 0, 0, "hist a");
        send(7, 0, 0, "hist b");
        out_ready = 1'b0;
        send(9, 0, 0, "hist c");
        check("pre-clear valid", out_valid, 1);
        pulse_clear();
        check("clear valid", out_valid, 0);
        check("clear in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++)
            send((i == 0) ? 17'sd1 : 17'sd0, h[i], 1,
                 $sformatf("post clr %0d", i));

        in_valid = 1'b1;
        in_data = 17'sd100;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mid rst valid", out_valid, 0);
        check("mid rst data", out_data, 0);
        check("mid rst in_ready", in_ready, 1);
        check("mid rst coef_ready", coef_ready, 1);
        #3 rst = 1'b1;
        tick();
        send(12345, 0, 1, "after rst");
        send(-4000, 0, 1, "after rst 2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
